// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states, opcode/funct values and ALU codes.
// Defining MIPS_BNE_EN adds the BNEEX state and the bne opcode decode.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWR   = 4'd4,
    MEMWB   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
`ifdef MIPS_BNE_EN
    , BNEEX = 4'd12
`endif
  } statetype;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALUCTL_AND = 3'b000;
  localparam logic [2:0] ALUCTL_OR  = 3'b001;
  localparam logic [2:0] ALUCTL_ADD = 3'b010;
  localparam logic [2:0] ALUCTL_SUB = 3'b110;
  localparam logic [2:0] ALUCTL_SLT = 3'b111;

  // ALUOP_NONE marks states that do not use the ALU, so alucontrol reads as all-zero there.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: turns the FSM's coarse aluop plus the R-type funct field into a 3-bit alucontrol.
module mips_aludec
  import mips_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALUCTL_AND;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALUCTL_ADD;
      ALUOP_SUB: alucontrol_o = ALUCTL_SUB;
      ALUOP_FUNCT: begin
        // Unsupported funct codes fall back to add without raising any flag.
        case (funct_i)
          FUNCT_SUB: alucontrol_o = ALUCTL_SUB;
          FUNCT_AND: alucontrol_o = ALUCTL_AND;
          FUNCT_OR:  alucontrol_o = ALUCTL_OR;
          FUNCT_SLT: alucontrol_o = ALUCTL_SLT;
          default:   alucontrol_o = ALUCTL_ADD;
        endcase
      end
      default: alucontrol_o = ALUCTL_AND;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: one state per cycle, stalls on memready, drives every datapath select/enable.
// Defining MIPS_BNE_EN enables the bne instruction (op 05) via a BNEEX state.
module mips_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsource,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       memtoreg,
  output logic       regdst,
  output logic       iord,
  output logic       regwrite,
  output logic       irwrite,
  output logic       memwrite,
  output logic       illegal_op
);

  statetype   state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite, branch;
`ifdef MIPS_BNE_EN
  logic       bne;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = FETCH;
    aluop      = ALUOP_NONE;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    pcwrite    = 1'b0;
    branch     = 1'b0;
`ifdef MIPS_BNE_EN
    bne        = 1'b0;
`endif
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    iord       = 1'b0;
    regwrite   = 1'b0;
    irwrite    = 1'b0;
    memwrite   = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      FETCH: begin
        alusrcb = 2'b01;
        aluop   = ALUOP_ADD;
        irwrite = memready;
        pcwrite = memready;
        state_d = memready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'b11;
        aluop   = ALUOP_ADD;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = RTYPEEX;
          OP_BEQ:       state_d = BEQEX;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JEX;
`ifdef MIPS_BNE_EN
          OP_BNE:       state_d = BNEEX;
`endif
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_ADD;
        state_d = (op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = memready ? MEMWB : MEMRD;
      end
      MEMWR: begin
        iord     = 1'b1;
        memwrite = memready;
        state_d  = memready ? FETCH : MEMWR;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = memready;
      end
      RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = RTYPEWB;
      end
      RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BEQEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsource = 2'b01;
        branch   = 1'b1;
      end
`ifdef MIPS_BNE_EN
      BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsource = 2'b01;
        bne      = 1'b1;
      end
`endif
      ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        aluop   = ALUOP_ADD;
        state_d = ADDIWB;
      end
      ADDIWB: regwrite = 1'b1;
      JEX: begin
        pcsource = 2'b10;
        pcwrite  = 1'b1;
      end
      default: state_d = FETCH;
    endcase

`ifdef MIPS_BNE_EN
    pcen = pcwrite | (branch & zero) | (bne & ~zero);
`else
    pcen = pcwrite | (branch & zero);
`endif

    // While reset is held every select and enable reads zero, so nothing is written mid-abort.
    if (!reset) begin
      aluop      = ALUOP_NONE;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsource   = 2'b00;
      pcen       = 1'b0;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      iord       = 1'b0;
      regwrite   = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      illegal_op = 1'b0;
    end
  end

  mips_aludec u_aludec (
    .aluop_i      (aluop),
    .funct_i      (funct),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Testbench for mips_controller: hand-written vector table plus randomized instruction stream vs. a phase-list model.
module tb_mips_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, memready;
  logic       alusrca, pcen, memtoreg, regdst, iord, regwrite, irwrite, memwrite, illegal_op;
  logic [1:0] alusrcb, pcsource;
  logic [2:0] alucontrol;

  int checks   = 0;
  int failures = 0;

  mips_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource), .alucontrol(alucontrol),
    .pcen(pcen), .memtoreg(memtoreg), .regdst(regdst), .iord(iord), .regwrite(regwrite),
    .irwrite(irwrite), .memwrite(memwrite), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Output vector layout: {alusrca, alusrcb, pcsource, alucontrol, pcen, memtoreg, regdst, iord,
  //                        regwrite, irwrite, memwrite, illegal_op}
  localparam logic [15:0] E_F    = 16'b0_01_00_010_1_0_0_0_0_1_0_0;
  localparam logic [15:0] E_FS   = 16'b0_01_00_010_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_D    = 16'b0_11_00_010_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_DI   = 16'b0_11_00_010_0_0_0_0_0_0_0_1;
  localparam logic [15:0] E_MA   = 16'b1_10_00_010_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_MR   = 16'b0_00_00_000_0_0_0_1_0_0_0_0;
  localparam logic [15:0] E_MWB  = 16'b0_00_00_000_0_1_0_0_1_0_0_0;
  localparam logic [15:0] E_MW   = 16'b0_00_00_000_0_0_0_1_0_0_1_0;
  localparam logic [15:0] E_RSLT = 16'b1_00_00_111_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_RSUB = 16'b1_00_00_110_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_RWB  = 16'b0_00_00_000_0_0_1_0_1_0_0_0;
  localparam logic [15:0] E_BT   = 16'b1_00_01_110_1_0_0_0_0_0_0_0;
  localparam logic [15:0] E_BN   = 16'b1_00_01_110_0_0_0_0_0_0_0_0;
  localparam logic [15:0] E_J    = 16'b0_00_10_000_1_0_0_0_0_0_0_0;
  localparam logic [15:0] E_AWB  = 16'b0_00_00_000_0_0_0_0_1_0_0_0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   seq[$];

  localparam int PH_F = 0, PH_D = 1, PH_MA = 2, PH_MR = 3, PH_MW = 4, PH_MWB = 5, PH_RX = 6,
                 PH_RWB = 7, PH_BX = 8, PH_BNX = 9, PH_AX = 10, PH_AWB = 11, PH_JX = 12;

  function automatic logic [15:0] actual();
    return {alusrca, alusrcb, pcsource, alucontrol, pcen, memtoreg, regdst, iord,
            regwrite, irwrite, memwrite, illegal_op};
  endfunction

  task automatic checkOutput(input logic [15:0] exp, input string name);
    logic [15:0] act;
    act = actual();
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs just after a rising edge, checks mid-cycle, then advances one edge.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic z,
                               input logic mr, input logic [15:0] exp, input string name);
    op = o; funct = f; zero = z; memready = mr;
    @(negedge clk);
    checkOutput(exp, name);
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [5:0] o, input logic [5:0] f, input logic z, input logic mr,
                        input logic [15:0] exp, input string name);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.mr = mr; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask

  function automatic bit isLegal(input logic [5:0] o);
    case (o)
      6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02: return 1'b1;
`ifdef MIPS_BNE_EN
      6'h05: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // Phase list an instruction walks through when memory never stalls.
  function automatic void buildSeq(input logic [5:0] o);
    seq = {PH_F, PH_D};
    case (o)
      6'h23: seq = {PH_F, PH_D, PH_MA, PH_MR, PH_MWB};
      6'h2B: seq = {PH_F, PH_D, PH_MA, PH_MW};
      6'h00: seq = {PH_F, PH_D, PH_RX, PH_RWB};
      6'h04: seq = {PH_F, PH_D, PH_BX};
      6'h08: seq = {PH_F, PH_D, PH_AX, PH_AWB};
      6'h02: seq = {PH_F, PH_D, PH_JX};
`ifdef MIPS_BNE_EN
      6'h05: seq = {PH_F, PH_D, PH_BNX};
`endif
      default: ;
    endcase
  endfunction

  function automatic bit isWaitPhase(input int ph);
    return (ph == PH_F) || (ph == PH_MR) || (ph == PH_MW);
  endfunction

  function automatic logic [2:0] functAlu(input logic [5:0] f);
    case (f)
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic logic [15:0] expOut(input int ph, input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic mr);
    logic a = 0, pe = 0, mt = 0, rd = 0, io = 0, rw = 0, ir = 0, mw = 0, il = 0;
    logic [1:0] b = 0, ps = 0;
    logic [2:0] ac = 0;
    case (ph)
      PH_F:   begin b = 2'b01; ac = 3'b010; ir = mr; pe = mr; end
      PH_D:   begin b = 2'b11; ac = 3'b010; il = !isLegal(o); end
      PH_MA, PH_AX: begin a = 1; b = 2'b10; ac = 3'b010; end
      PH_MR:  io = 1;
      PH_MW:  begin io = 1; mw = mr; end
      PH_MWB: begin mt = 1; rw = mr; end
      PH_RX:  begin a = 1; ac = functAlu(f); end
      PH_RWB: begin rd = 1; rw = 1; end
      PH_BX:  begin a = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      PH_BNX: begin a = 1; ac = 3'b110; ps = 2'b01; pe = !z; end
      PH_AWB: rw = 1;
      PH_JX:  begin ps = 2'b10; pe = 1; end
      default: ;
    endcase
    return {a, b, ps, ac, pe, mt, rd, io, rw, ir, mw, il};
  endfunction

  initial begin
    logic [5:0] rop, rfn;
    logic       rz, rmr;
    int         idx, stall;
    logic [5:0] opPool[8];
    logic [5:0] fnPool[6];

    opPool = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02, 6'h05, 6'h3F};
    fnPool = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};

    reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; memready = 1'b1;
    @(posedge clk); #1;
    checkOutput(16'h0000, "reset_low_outputs");
    @(posedge clk); #1;
    checkOutput(16'h0000, "reset_low_after_edge");
    reset = 1'b1;

    // lw, R-type slt/sub, addi, beq taken/not, j, illegal, sw with stalls.
    addVec(6'h23, 0, 0, 1, E_F,   "lw_fetch");
    addVec(6'h23, 0, 0, 1, E_D,   "lw_decode");
    addVec(6'h23, 0, 0, 1, E_MA,  "lw_memadr");
    addVec(6'h23, 0, 0, 1, E_MR,  "lw_memrd");
    addVec(6'h23, 0, 0, 1, E_MWB, "lw_memwb");
    addVec(6'h00, 6'h2A, 0, 1, E_F,    "slt_fetch");
    addVec(6'h00, 6'h2A, 0, 1, E_D,    "slt_decode");
    addVec(6'h00, 6'h2A, 0, 1, E_RSLT, "slt_ex");
    addVec(6'h00, 6'h2A, 0, 1, E_RWB,  "slt_wb");
    addVec(6'h00, 6'h22, 0, 1, E_F,    "sub_fetch");
    addVec(6'h00, 6'h22, 0, 1, E_D,    "sub_decode");
    addVec(6'h00, 6'h22, 0, 1, E_RSUB, "sub_ex");
    addVec(6'h00, 6'h22, 0, 1, E_RWB,  "sub_wb");
    addVec(6'h08, 0, 0, 1, E_F,   "addi_fetch");
    addVec(6'h08, 0, 0, 1, E_D,   "addi_decode");
    addVec(6'h08, 0, 0, 1, E_MA,  "addi_ex");
    addVec(6'h08, 0, 0, 1, E_AWB, "addi_wb");
    addVec(6'h04, 0, 1, 1, E_F,  "beqt_fetch");
    addVec(6'h04, 0, 1, 1, E_D,  "beqt_decode");
    addVec(6'h04, 0, 1, 1, E_BT, "beq_taken");
    addVec(6'h04, 0, 0, 1, E_F,  "beqn_fetch");
    addVec(6'h04, 0, 0, 1, E_D,  "beqn_decode");
    addVec(6'h04, 0, 0, 1, E_BN, "beq_not_taken");
    addVec(6'h02, 0, 0, 1, E_F,  "j_fetch");
    addVec(6'h02, 0, 0, 1, E_D,  "j_decode");
    addVec(6'h02, 0, 0, 1, E_J,  "j_ex");
    addVec(6'h3F, 0, 0, 1, E_F,  "ill_fetch");
    addVec(6'h3F, 0, 0, 1, E_DI, "ill_decode");
    for (int i = 0; i < 3; i++) addVec(6'h2B, 0, 0, 0, E_FS, "sw_fetch_stall");
    addVec(6'h2B, 0, 0, 1, E_F,  "sw_fetch");
    addVec(6'h2B, 0, 0, 1, E_D,  "sw_decode");
    addVec(6'h2B, 0, 0, 1, E_MA, "sw_memadr");
    for (int i = 0; i < 3; i++) addVec(6'h2B, 0, 0, 0, E_MR, "sw_memwr_stall");
    addVec(6'h2B, 0, 0, 1, E_MW, "sw_memwr");
`ifdef MIPS_BNE_EN
    addVec(6'h05, 0, 0, 1, E_F,  "bne_fetch");
    addVec(6'h05, 0, 0, 1, E_D,  "bne_decode");
    addVec(6'h05, 0, 0, 1, E_BT, "bne_taken");
    addVec(6'h05, 0, 1, 1, E_F,  "bnen_fetch");
    addVec(6'h05, 0, 1, 1, E_D,  "bnen_decode");
    addVec(6'h05, 0, 1, 1, E_BN, "bne_not_taken");
`else
    addVec(6'h05, 0, 0, 1, E_F,  "bne_fetch");
    addVec(6'h05, 0, 0, 1, E_DI, "bne_illegal");
`endif
    addVec(6'h00, 0, 0, 0, E_FS, "final_fetch_stall");

    foreach (vecs[i])
      applyStimulus(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].mr, vecs[i].exp, vecs[i].name);

    // Abort a lw in MEMADR with reset, then restart cleanly from FETCH.
    applyStimulus(6'h23, 0, 0, 1, E_F,  "rst_lw_fetch");
    applyStimulus(6'h23, 0, 0, 1, E_D,  "rst_lw_decode");
    #2 reset = 1'b0;
    #1 checkOutput(16'h0000, "rst_mid_memadr");
    @(posedge clk); #1;
    checkOutput(16'h0000, "rst_held_edge");
    memready = 1'b0;
    reset = 1'b1;
    applyStimulus(6'h23, 0, 0, 0, E_FS, "rst_release_fetch");
    applyStimulus(6'h23, 0, 0, 1, E_F,  "rst_release_fetch_go");
    applyStimulus(6'h23, 0, 0, 1, E_D,  "rst_release_decode");
    applyStimulus(6'h23, 0, 0, 1, E_MA, "rst_release_memadr");
    applyStimulus(6'h23, 0, 0, 1, E_MR, "rst_release_memrd");
    applyStimulus(6'h23, 0, 0, 1, E_MWB, "rst_release_memwb");

    // Randomized instruction stream with random zero and memready.
    for (int k = 0; k < 300; k++) begin
      rop = ($urandom_range(0, 4) == 0) ? 6'($urandom) : opPool[$urandom_range(0, 7)];
      rfn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fnPool[$urandom_range(0, 5)];
      buildSeq(rop);
      idx = 0;
      stall = 0;
      while (idx < seq.size()) begin
        rz  = 1'($urandom);
        rmr = ($urandom_range(0, 3) != 0) || (stall >= 8);
        applyStimulus(rop, rfn, rz, rmr, expOut(seq[idx], rop, rfn, rz, rmr),
                      $sformatf("rand_op%02h_ph%0d", rop, seq[idx]));
        if (!isWaitPhase(seq[idx]) || rmr) begin
          idx++;
          stall = 0;
        end else begin
          stall++;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
